// File: rtl/fcs_frame_ctrl_if.sv
// Requester-side byte-stream bundle for the FCS frame controller.
// master = requesters, slave = frame controller.
interface fcs_frame_ctrl_if #(
    parameter int NUM_REQ = 2
);
    logic [NUM_REQ-1:0]   req;
    logic [NUM_REQ*8-1:0] byte_data;
    logic [NUM_REQ-1:0]   byte_valid;
    logic [NUM_REQ-1:0]   byte_last;
    logic [NUM_REQ-1:0]   byte_ready;
    logic [NUM_REQ-1:0]   grant;

    modport master (
        output req, byte_data, byte_valid, byte_last,
        input  byte_ready, grant
    );

    modport slave (
        input  req, byte_data, byte_valid, byte_last,
        output byte_ready, grant
    );
endinterface

// File: rtl/fcs_frame_ctrl.sv
// Round-robin frame sequencer feeding a serial 16-bit FCS engine.
// Streams data bits LSB-first, then the engine's 16 FCS bits, as one tx stream.
module fcs_frame_ctrl #(
    parameter int NUM_REQ = 2,
    parameter int IFG     = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    fcs_frame_ctrl_if.slave   rq,
    output logic              fcs_data,
    output logic              fcs_start,
    input  logic              fcs_bit,
    input  logic              fcs_valid,
    output logic              tx_bit,
    output logic              tx_valid,
    output logic              tx_sof,
    output logic              tx_eof,
    output logic              frame_done,
    output logic              frame_err,
    output logic              busy
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int GW = $clog2(IFG) + 1;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SHIFT, S_FCS, S_GAP} state_t;

    state_t               state_reg, state_next;
    logic [IW-1:0]        ptr_reg, ptr_next;
    logic [NUM_REQ-1:0]   grant_reg, grant_next;
    logic [7:0]           shreg_reg, shreg_next;
    logic                 last_reg, last_next;
    logic                 first_reg, first_next;
    logic                 abort_reg, abort_next;
    logic                 errseen_reg, errseen_next;
    logic [2:0]           bitcnt_reg, bitcnt_next;
    logic [3:0]           fcnt_reg, fcnt_next;
    logic [GW-1:0]        gcnt_reg, gcnt_next;
    logic                 tx_bit_reg, tx_valid_reg, tx_sof_reg, tx_eof_reg;
    logic                 frame_done_reg, frame_err_reg;

    logic                 rdy_en;
    logic                 err_pulse;
    logic                 win_found;
    logic [IW-1:0]        win_idx;
    logic [7:0]           lane_byte;
    logic                 lane_valid;
    logic                 lane_last;
    logic [7:0]           lane_bytes [NUM_REQ];

    function automatic logic [IW-1:0] lane_at(input logic [IW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return IW'(s);
    endfunction

    // Only the granted lane contributes to the byte mux.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
        assign lane_bytes[gi] = grant_reg[gi] ? rq.byte_data[8*gi +: 8] : 8'h00;
    end

    always_comb begin
        lane_byte = 8'h00;
        for (int k = 0; k < NUM_REQ; k++) lane_byte = lane_byte | lane_bytes[k];
    end

    assign lane_valid = |(rq.byte_valid & grant_reg);
    assign lane_last  = |(rq.byte_last & grant_reg);

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!win_found && rq.req[lane_at(ptr_reg, k)]) begin
                win_found = 1'b1;
                win_idx   = lane_at(ptr_reg, k);
            end
        end
    end

    always_comb begin
        state_next   = state_reg;
        ptr_next     = ptr_reg;
        grant_next   = grant_reg;
        shreg_next   = shreg_reg;
        last_next    = last_reg;
        first_next   = first_reg;
        abort_next   = abort_reg;
        errseen_next = errseen_reg;
        bitcnt_next  = bitcnt_reg;
        fcnt_next    = fcnt_reg;
        gcnt_next    = gcnt_reg;
        fcs_start    = 1'b0;
        fcs_data     = 1'b0;
        rdy_en       = 1'b0;
        err_pulse    = 1'b0;
        unique case (state_reg)
            S_IDLE: begin
                if (win_found) begin
                    grant_next   = NUM_REQ'(1) << win_idx;
                    ptr_next     = lane_at(win_idx, 1);
                    abort_next   = 1'b0;
                    errseen_next = 1'b0;
                    state_next   = S_LOAD;
                end
            end
            S_LOAD: begin
                rdy_en = 1'b1;
                if (lane_valid) begin
                    shreg_next  = lane_byte;
                    last_next   = lane_last;
                    bitcnt_next = 3'd0;
                    first_next  = 1'b1;
                    state_next  = S_SHIFT;
                end
            end
            S_SHIFT: begin
                fcs_start   = 1'b1;
                fcs_data    = shreg_reg[0];
                shreg_next  = {1'b0, shreg_reg[7:1]};
                bitcnt_next = bitcnt_reg + 3'd1;
                first_next  = 1'b0;
                if (bitcnt_reg == 3'd7) begin
                    if (last_reg) begin
                        fcnt_next  = 4'd0;
                        state_next = S_FCS;
                    end else begin
                        rdy_en = 1'b1;
                        if (lane_valid) begin
                            // Back-to-back reload keeps fcs_start continuous across bytes.
                            shreg_next  = lane_byte;
                            last_next   = lane_last;
                            bitcnt_next = 3'd0;
                        end else begin
                            abort_next   = 1'b1;
                            errseen_next = 1'b1;
                            err_pulse    = 1'b1;
                            fcnt_next    = 4'd0;
                            state_next   = S_FCS;
                        end
                    end
                end
            end
            S_FCS: begin
                // Runs all 16 cycles even on abort so the engine register drains to zero.
                fcnt_next = fcnt_reg + 4'd1;
                if (!fcs_valid && !errseen_reg) begin
                    err_pulse    = 1'b1;
                    errseen_next = 1'b1;
                end
                if (fcnt_reg == 4'd15) begin
                    gcnt_next  = '0;
                    state_next = S_GAP;
                end
            end
            S_GAP: begin
                gcnt_next = gcnt_reg + GW'(1);
                if (gcnt_reg == GW'(IFG - 1)) begin
                    grant_next = '0;
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= S_IDLE;
            ptr_reg        <= '0;
            grant_reg      <= '0;
            shreg_reg      <= 8'h00;
            last_reg       <= 1'b0;
            first_reg      <= 1'b0;
            abort_reg      <= 1'b0;
            errseen_reg    <= 1'b0;
            bitcnt_reg     <= 3'd0;
            fcnt_reg       <= 4'd0;
            gcnt_reg       <= '0;
            tx_bit_reg     <= 1'b0;
            tx_valid_reg   <= 1'b0;
            tx_sof_reg     <= 1'b0;
            tx_eof_reg     <= 1'b0;
            frame_done_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
        end else begin
            state_reg      <= state_next;
            ptr_reg        <= ptr_next;
            grant_reg      <= grant_next;
            shreg_reg      <= shreg_next;
            last_reg       <= last_next;
            first_reg      <= first_next;
            abort_reg      <= abort_next;
            errseen_reg    <= errseen_next;
            bitcnt_reg     <= bitcnt_next;
            fcnt_reg       <= fcnt_next;
            gcnt_reg       <= gcnt_next;
            tx_bit_reg     <= (state_reg == S_SHIFT) ? fcs_data :
                              ((state_reg == S_FCS) && !abort_reg) ? fcs_bit : 1'b0;
            tx_valid_reg   <= (state_reg == S_SHIFT) || ((state_reg == S_FCS) && !abort_reg);
            tx_sof_reg     <= (state_reg == S_SHIFT) && first_reg;
            tx_eof_reg     <= (state_reg == S_FCS) && (fcnt_reg == 4'd15) && !abort_reg;
            frame_done_reg <= tx_eof_reg;
            frame_err_reg  <= err_pulse;
        end
    end

    assign rq.byte_ready = rdy_en ? grant_reg : '0;
    assign rq.grant      = grant_reg;
    assign tx_bit        = tx_bit_reg;
    assign tx_valid      = tx_valid_reg;
    assign tx_sof        = tx_sof_reg;
    assign tx_eof        = tx_eof_reg;
    assign frame_done    = frame_done_reg;
    assign frame_err     = frame_err_reg;
    assign busy          = (state_reg != S_IDLE);
endmodule

// File: tb/tb_fcs_frame_ctrl.sv
// Bench for fcs_frame_ctrl: serial CRC-16 (0x1021, init 0) engine model,
// per-lane byte sources and a tx-stream scoreboard built from frame contents.
module tb_fcs_frame_ctrl;
    localparam int NR  = 2;
    localparam int IFG = 4;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    fcs_frame_ctrl_if #(.NUM_REQ(NR)) rq ();
    logic fcs_data, fcs_start, fcs_bit, fcs_valid;
    logic tx_bit, tx_valid, tx_sof, tx_eof, frame_done, frame_err, busy;

    fcs_frame_ctrl #(.NUM_REQ(NR), .IFG(IFG)) dut (
        .clock(clock), .reset_n(reset_n), .rq(rq),
        .fcs_data(fcs_data), .fcs_start(fcs_start),
        .fcs_bit(fcs_bit), .fcs_valid(fcs_valid),
        .tx_bit(tx_bit), .tx_valid(tx_valid), .tx_sof(tx_sof), .tx_eof(tx_eof),
        .frame_done(frame_done), .frame_err(frame_err), .busy(busy)
    );

    // Serial FCS engine: shifts data in while fcs_start, otherwise shifts the CRC out MSB-first.
    logic [15:0] eng;
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) eng <= 16'h0000;
        else if (fcs_start) eng <= {eng[14:0], 1'b0} ^ ((eng[15] ^ fcs_data) ? 16'h1021 : 16'h0000);
        else eng <= {eng[14:0], 1'b0};
    end
    assign fcs_bit   = eng[15];
    assign fcs_valid = !fcs_start;

    int nvec = 0, nerr = 0, cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] crc_of(input logic [31:0] bytes, input int n);
        logic [15:0] c;
        logic fb;
        c = 16'h0000;
        for (int i = 0; i < n; i++)
            for (int j = 0; j < 8; j++) begin
                fb = c[15] ^ bytes[8*i+j];
                c  = {c[14:0], 1'b0};
                if (fb) c = c ^ 16'h1021;
            end
        return c;
    endfunction

    // Expected tx stream, one entry per valid bit.
    bit eb[$], esof[$], eeof[$], eend[$];
    logic [NR-1:0] egr[$];
    logic [8:0] lq0[$], lq1[$];

    task automatic add_frame(input int lane, input int n, input logic [31:0] bytes, input bit abort);
        logic [7:0] b;
        logic [15:0] c;
        for (int i = 0; i < n; i++) begin
            b = bytes[8*i +: 8];
            if (lane == 0) lq0.push_back({(i == n-1) && !abort, b});
            else           lq1.push_back({(i == n-1) && !abort, b});
            for (int j = 0; j < 8; j++) begin
                eb.push_back(b[j]); esof.push_back(i == 0 && j == 0); eeof.push_back(1'b0);
                eend.push_back(abort && i == n-1 && j == 7); egr.push_back(NR'(1) << lane);
            end
        end
        if (!abort) begin
            c = crc_of(bytes, n);
            for (int j = 15; j >= 0; j--) begin
                eb.push_back(c[j]); esof.push_back(1'b0); eeof.push_back(j == 0);
                eend.push_back(j == 0); egr.push_back(NR'(1) << lane);
            end
        end
    endtask

    // Byte sources: valid whenever a byte is queued, pop on a handshake.
    int nfire = 0;
    initial begin
        bit f0, f1;
        rq.req = '0; rq.byte_valid = '0; rq.byte_last = '0; rq.byte_data = '0;
        forever begin
            @(negedge clock);
            f0 = rq.byte_valid[0] & rq.byte_ready[0];
            f1 = rq.byte_valid[1] & rq.byte_ready[1];
            @(posedge clock);
            #1;
            if (f0 && lq0.size() > 0) begin void'(lq0.pop_front()); nfire++; end
            if (f1 && lq1.size() > 0) begin void'(lq1.pop_front()); nfire++; end
            rq.req[0] = lq0.size() > 0; rq.byte_valid[0] = lq0.size() > 0;
            rq.req[1] = lq1.size() > 0; rq.byte_valid[1] = lq1.size() > 0;
            rq.byte_last[0] = (lq0.size() > 0) ? lq0[0][8] : 1'b0;
            rq.byte_last[1] = (lq1.size() > 0) ? lq1[0][8] : 1'b0;
            rq.byte_data[7:0]  = (lq0.size() > 0) ? lq0[0][7:0] : 8'h00;
            rq.byte_data[15:8] = (lq1.size() > 0) ? lq1[0][7:0] : 8'h00;
        end
    end

    // Compare process: every cycle out of reset.
    bit in_frame = 0, prev_eof = 0, busy_prev = 0;
    int fbits = 0, cap_len = 0, last_eof_cyc = 0, last_gap = 0, err_cyc = 0, idle_cyc = 0;
    int nerrp = 0, ndone = 0;
    logic [15:0] last16 = 16'h0, cap_fcs = 16'h0;
    initial begin
        bit b, s, e, en;
        logic [NR-1:0] g;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                in_frame = 0; prev_eof = 0; busy_prev = 0;
            end else begin
                chk("frame_done", 32'(frame_done), 32'(prev_eof));
                prev_eof = tx_eof;
                if (frame_done) ndone++;
                if (frame_err) begin nerrp++; err_cyc = cyc; end
                if (busy_prev && !busy) idle_cyc = cyc;
                busy_prev = busy;
                if (tx_valid) begin
                    if (eb.size() == 0) begin
                        nvec++; nerr++;
                        $display("FAIL tx_unexpected: tx_valid=1 with no frame bit pending (cycle %0d)", cyc);
                    end else begin
                        b = eb.pop_front(); s = esof.pop_front(); e = eeof.pop_front();
                        en = eend.pop_front(); g = egr.pop_front();
                        chk("tx_bit", 32'(tx_bit), 32'(b));
                        chk("tx_sof", 32'(tx_sof), 32'(s));
                        chk("tx_eof", 32'(tx_eof), 32'(e));
                        if (s) begin
                            chk("grant", 32'(rq.grant), 32'(g));
                            last_gap = cyc - last_eof_cyc;
                            fbits = 0;
                        end
                        fbits++;
                        last16 = {last16[14:0], tx_bit};
                        if (tx_eof) begin cap_fcs = last16; cap_len = fbits; last_eof_cyc = cyc; end
                        in_frame = !en;
                    end
                end else begin
                    chk("tx_idle_flags", 32'({tx_sof, tx_eof}), 32'd0);
                    if (in_frame) begin
                        nvec++; nerr++;
                        $display("FAIL tx_gap: tx_valid=0 inside frame, required 1 (cycle %0d)", cyc);
                        in_frame = 0;
                    end
                end
            end
        end
    end

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while ((lq0.size() > 0 || lq1.size() > 0 || eb.size() > 0 || busy) && n < 400) begin
            @(posedge clock);
            n++;
        end
        chk({name, "_timeout"}, 32'(n >= 400), 32'd0);
        repeat (3) @(posedge clock);
    endtask

    initial begin
        int d0, f0, e0, n;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_outs", 32'({tx_bit, tx_valid, tx_sof, tx_eof, frame_done, frame_err, busy,
                             fcs_start, fcs_data, rq.grant, rq.byte_ready}), 32'd0);
        chk("model_crc_01", 32'(crc_of(32'h01, 1)), 32'h9188);
        chk("model_crc_0000", 32'(crc_of(32'h0, 2)), 32'h0000);
        #2 reset_n = 1'b1;

        // Round robin: both lanes requesting from reset, then again.
        d0 = ndone;
        add_frame(0, 1, 32'hA5, 0);
        add_frame(1, 1, 32'h3C, 0);
        wait_done("rr1");
        chk("rr1_gap", 32'(last_gap), 32'(IFG + 3));
        add_frame(0, 1, 32'h81, 0);
        add_frame(1, 1, 32'h7E, 0);
        wait_done("rr2");
        chk("rr_done", 32'(ndone - d0), 32'd4);

        // Single byte 0x01.
        d0 = ndone;
        add_frame(0, 1, 32'h01, 0);
        wait_done("b01");
        chk("b01_len", 32'(cap_len), 32'd24);
        chk("b01_fcs", 32'(cap_fcs), 32'h9188);
        chk("b01_done", 32'(ndone - d0), 32'd1);

        // Two zero bytes.
        f0 = nfire;
        add_frame(0, 2, 32'h0000, 0);
        wait_done("z2");
        chk("z2_len", 32'(cap_len), 32'd32);
        chk("z2_fcs", 32'(cap_fcs), 32'h0000);
        chk("z2_ready", 32'(nfire - f0), 32'd2);

        // Three bytes, valid held: contiguous 40 bits.
        f0 = nfire;
        add_frame(1, 3, 32'h563412, 0);
        wait_done("b3");
        chk("b3_len", 32'(cap_len), 32'd40);
        chk("b3_ready", 32'(nfire - f0), 32'd3);

        // Underrun after one byte, then a clean frame.
        d0 = ndone; e0 = nerrp;
        add_frame(0, 1, 32'h77, 1);
        wait_done("ab");
        chk("ab_err", 32'(nerrp - e0), 32'd1);
        chk("ab_busy", 32'(idle_cyc - err_cyc), 32'(16 + IFG));
        chk("ab_done", 32'(ndone - d0), 32'd0);
        add_frame(1, 2, 32'hBEEF, 0);
        wait_done("post_ab");
        chk("post_ab_fcs", 32'(cap_fcs), 32'(crc_of(32'hBEEF, 2)));
        chk("post_ab_err", 32'(nerrp - e0), 32'd1);

        // Reset during the FCS phase.
        fbits = 0;
        add_frame(0, 1, 32'hC3, 0);
        n = 0;
        while (fbits < 12 && n < 200) begin @(posedge clock); n++; end
        chk("rst_wait_timeout", 32'(n >= 200), 32'd0);
        #3 reset_n = 1'b0;
        #1;
        chk("midrst_outs", 32'({tx_bit, tx_valid, tx_sof, tx_eof, frame_done, frame_err, busy,
                                fcs_start, fcs_data, rq.grant, rq.byte_ready}), 32'd0);
        eb.delete(); esof.delete(); eeof.delete(); eend.delete(); egr.delete();
        lq0.delete(); lq1.delete();
        repeat (2) @(posedge clock);
        #3 reset_n = 1'b1;
        d0 = ndone; e0 = nerrp;
        add_frame(1, 1, 32'h5A, 0);
        wait_done("post_rst");
        chk("post_rst_fcs", 32'(cap_fcs), 32'(crc_of(32'h5A, 1)));
        chk("post_rst_done", 32'(ndone - d0), 32'd1);
        chk("post_rst_err", 32'(nerrp - e0), 32'd0);
        chk("sb_empty", 32'(eb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
